mem_stage: RTL and testbench

- Memory-access stage of the 5-stage LoongArch pipeline: sits between execute and writeback.
- Latches the execute-stage bus and waits for the SRAM-like data_ok response of any data request issued upstream.
- Aligns and sign/zero-extends load data, and forwards dest/value and hazard info to decode.
- Raises ms_int so the upstream stage suppresses stores behind an excepting/ertn instruction.
- Absorbs stale responses after a writeback flush.

---
 rtl/mem_pkg.sv | 53 +++++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared bus layouts and load-op encodings for the memory stage
package mem_pkg;

  localparam int ES_BUS_BITS = 143;
  localparam int WS_BUS_BITS = 137;

  localparam int LD_OP_W    = 5;
  localparam int EX_CAUSE_W = 17;
  localparam int CSR_NUM_W  = 14;
  localparam int REG_W      = 5;

  // One-hot ld_op bit positions
  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  // ex_cause bit raised by execute for a misaligned address
  localparam int EX_ALE = 3;

  // Member order is MSB first, so these structs are the field offset map
  typedef struct packed {
    logic                  rdcntid;
    logic                  ertn;
    logic                  csr_we;
    logic                  csr_rd;
    logic [31:0]           csr_wmask;
    logic [CSR_NUM_W-1:0]  csr_num;
    logic [EX_CAUSE_W-1:0] ex_cause;
    logic [LD_OP_W-1:0]    ld_op;
    logic                  res_from_mem;
    logic                  gr_we;
    logic [REG_W-1:0]      dest;
    logic [31:0]           result;
    logic [31:0]           pc;
  } es_bus_t;

  typedef struct packed {
    logic                  rdcntid;
    logic                  ertn;
    logic                  csr_we;
    logic                  csr_rd;
    logic [31:0]           csr_wmask;
    logic [CSR_NUM_W-1:0]  csr_num;
    logic [EX_CAUSE_W-1:0] ex_cause;
    logic                  gr_we;
    logic [REG_W-1:0]      dest;
    logic [31:0]           final_result;
    logic [31:0]           pc;
  } ws_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects the addressed byte/half of a load word and extends it
module mem_load_align
  import mem_pkg::*;
(
  input  logic [LD_OP_W-1:0] ld_op_i,
  input  logic [1:0]         off_i,
  input  logic [31:0]        rdata_i,
  output logic [31:0]        data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    if (ld_op_i[LD_W]) begin
      data_o = rdata_i;
    end else if (ld_op_i[LD_B]) begin
      data_o = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_op_i[LD_BU]) begin
      data_o = {24'd0, byte_sel};
    end else if (ld_op_i[LD_H]) begin
      data_o = {{16{half_sel[15]}}, half_sel};
    end else if (ld_op_i[LD_HU]) begin
      data_o = {16'd0, half_sel};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between execute and writeback
// Waits for the data response of the held instruction, buffers it under backpressure.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ES_BUS_W = ES_BUS_BITS,
  parameter int WS_BUS_W = WS_BUS_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ws_allowin,
  output logic                ms_allowin,
  input  logic                es_to_ms_valid,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  input  logic                es_to_ms_mem_req,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  output logic                ms_to_ws_valid,
  output logic [WS_BUS_W-1:0] ms_to_ws_bus,
  output logic [4:0]          ms_to_ds_dest,
  output logic [31:0]         ms_to_ds_value,
  output logic                ms_value_pending,
  output logic                ms_int,
  output logic                ms_csr,
  output logic                ms_tid,
  input  logic                ws_reflush_ms
);

  es_bus_t     bus_q, bus_d;
  logic        ms_valid_q, ms_valid_d;
  logic        req_q, req_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q, buf_d;
  logic        discard_q, discard_d;

  logic        waiting;
  logic        live_ok;
  logic        ready_go;
  logic        accept;
  logic        retire;
  logic [31:0] rd_word;
  logic [31:0] load_data;
  logic [31:0] final_result;
  ws_bus_t     ws_bus;

  always_comb begin
    waiting    = ms_valid_q & req_q & ~buf_valid_q;
    // A response arriving while discard is set belongs to a flushed instruction
    live_ok    = data_sram_data_ok & ~discard_q;
    ready_go   = ~req_q | buf_valid_q | live_ok;
    ms_allowin = ~ms_valid_q | (ready_go & ws_allowin);
    accept     = es_to_ms_valid & ms_allowin;
    retire     = ms_valid_q & ready_go & ws_allowin;
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (ws_reflush_ms) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end

    bus_d = bus_q;
    req_d = req_q;
    if (accept) begin
      bus_d = es_bus_t'(es_to_ms_bus);
      req_d = es_to_ms_mem_req;
    end

    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    if (ws_reflush_ms | retire) begin
      buf_valid_d = 1'b0;
    end else if (waiting & live_ok & ~ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_d       = data_sram_rdata;
    end

    // Flush while the response is still in flight: swallow it when it lands
    discard_d = discard_q;
    if (ws_reflush_ms & waiting & ~data_sram_data_ok) begin
      discard_d = 1'b1;
    end else if (data_sram_data_ok) begin
      discard_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q  <= 1'b0;
      req_q       <= 1'b0;
      bus_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      discard_q   <= 1'b0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      req_q       <= req_d;
      bus_q       <= bus_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      discard_q   <= discard_d;
    end
  end

  assign rd_word = buf_valid_q ? buf_q : data_sram_rdata;

  mem_load_align u_load_align (
    .ld_op_i (bus_q.ld_op),
    .off_i   (bus_q.result[1:0]),
    .rdata_i (rd_word),
    .data_o  (load_data)
  );

  // An excepting load never got data; its result field carries the bad vaddr
  assign final_result = (bus_q.res_from_mem & ~|bus_q.ex_cause) ? load_data : bus_q.result;

  always_comb begin
    ws_bus.rdcntid      = bus_q.rdcntid;
    ws_bus.ertn         = bus_q.ertn;
    ws_bus.csr_we       = bus_q.csr_we;
    ws_bus.csr_rd       = bus_q.csr_rd;
    ws_bus.csr_wmask    = bus_q.csr_wmask;
    ws_bus.csr_num      = bus_q.csr_num;
    ws_bus.ex_cause     = bus_q.ex_cause;
    ws_bus.gr_we        = bus_q.gr_we;
    ws_bus.dest         = bus_q.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = bus_q.pc;
  end

  assign ms_to_ws_bus     = ws_bus;
  assign ms_to_ws_valid   = ms_valid_q & ready_go & ~ws_reflush_ms;
  assign ms_to_ds_dest    = (ms_valid_q & bus_q.gr_we) ? bus_q.dest : 5'd0;
  assign ms_to_ds_value   = final_result;
  assign ms_value_pending = ms_valid_q & bus_q.res_from_mem & ~ready_go;
  assign ms_int           = ms_valid_q & ((|bus_q.ex_cause) | bus_q.ertn);
  assign ms_csr           = ms_valid_q & (bus_q.csr_we | bus_q.csr_rd);
  assign ms_tid           = ms_valid_q & bus_q.rdcntid;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed bench for mem_stage with a transaction-level reference model
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         ws_allowin = 1'b1;
  logic         ms_allowin;
  logic         es_to_ms_valid = 1'b0;
  logic [142:0] es_to_ms_bus = '0;
  logic         es_to_ms_mem_req = 1'b0;
  logic         data_sram_data_ok = 1'b0;
  logic [31:0]  data_sram_rdata = '0;
  logic         ms_to_ws_valid;
  logic [136:0] ms_to_ws_bus;
  logic [4:0]   ms_to_ds_dest;
  logic [31:0]  ms_to_ds_value;
  logic         ms_value_pending;
  logic         ms_int;
  logic         ms_csr;
  logic         ms_tid;
  logic         ws_reflush_ms = 1'b0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_to_ms_mem_req  (es_to_ms_mem_req),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_dest     (ms_to_ds_dest),
    .ms_to_ds_value    (ms_to_ds_value),
    .ms_value_pending  (ms_value_pending),
    .ms_int            (ms_int),
    .ms_csr            (ms_csr),
    .ms_tid            (ms_tid),
    .ws_reflush_ms     (ws_reflush_ms)
  );

  typedef struct packed {
    logic        rdcntid;
    logic        ertn;
    logic        csr_we;
    logic        csr_rd;
    logic [31:0] csr_wmask;
    logic [13:0] csr_num;
    logic [16:0] ex_cause;
    logic [4:0]  ld_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } inst_t;

  localparam logic [4:0] OP_B  = 5'b00001;
  localparam logic [4:0] OP_BU = 5'b00010;
  localparam logic [4:0] OP_H  = 5'b00100;
  localparam logic [4:0] OP_HU = 5'b01000;
  localparam logic [4:0] OP_W  = 5'b10000;

  int    n_vec = 0;
  int    n_err = 0;
  bit    chk_en = 1'b0;
  inst_t cur_inst = '0;

  // Reference model: the instruction held, whether its data has been kept, stale responses owed
  bit          m_valid = 1'b0;
  bit          m_req = 1'b0;
  bit          m_have = 1'b0;
  logic [31:0] m_data = '0;
  int          m_stale = 0;
  inst_t       m_inst = '0;

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_final(input inst_t i, input logic [31:0] rd);
    int unsigned off;
    int unsigned v;
    off = 32'(i.result[1:0]);
    if (!i.res_from_mem || i.ex_cause != 17'd0) return i.result;
    if (i.ld_op == OP_W) return rd;
    if (i.ld_op == OP_B || i.ld_op == OP_BU) begin
      v = (rd >> (8 * off)) & 32'hff;
      if (i.ld_op == OP_B && v >= 128) v = v - 256;
      return v;
    end
    v = (rd >> (16 * (off / 2))) & 32'hffff;
    if (i.ld_op == OP_H && v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic logic [136:0] model_bus(input inst_t i, input logic [31:0] rd);
    return {i.rdcntid, i.ertn, i.csr_we, i.csr_rd, i.csr_wmask, i.csr_num, i.ex_cause,
            i.gr_we, i.dest, model_final(i, rd), i.pc};
  endfunction

  function automatic inst_t mk_load(input logic [4:0] op, input logic [31:0] addr, input logic [4:0] dst);
    inst_t t;
    t = '0;
    t.ld_op = op;
    t.res_from_mem = 1'b1;
    t.gr_we = 1'b1;
    t.dest = dst;
    t.result = addr;
    t.pc = 32'h1c00_0100 ^ addr;
    return t;
  endfunction

  always @(posedge clk) begin : model_step
    bit live, ready, wait_m, allow;
    if (!resetn) begin
      m_valid = 1'b0;
      m_req   = 1'b0;
      m_have  = 1'b0;
      m_stale = 0;
    end else begin
      live   = data_sram_data_ok && (m_stale == 0);
      ready  = !m_req || m_have || live;
      wait_m = m_valid && m_req && !m_have;
      allow  = !m_valid || (ready && ws_allowin);
      if (ws_reflush_ms || (m_valid && ready && ws_allowin)) m_have = 1'b0;
      else if (wait_m && live) begin
        m_have = 1'b1;
        m_data = data_sram_rdata;
      end
      if (data_sram_data_ok && m_stale > 0) m_stale--;
      else if (ws_reflush_ms && wait_m && !data_sram_data_ok) m_stale++;
      if (allow && es_to_ms_valid) begin
        m_inst = cur_inst;
        m_req  = es_to_ms_mem_req;
      end
      if (ws_reflush_ms) m_valid = 1'b0;
      else if (allow) m_valid = es_to_ms_valid;
    end
  end

  always @(negedge clk) begin : compare
    bit live, ready, tv;
    logic [31:0] rd;
    if (chk_en) begin
      live  = data_sram_data_ok && (m_stale == 0);
      ready = !m_req || m_have || live;
      tv    = m_valid && ready && !ws_reflush_ms;
      rd    = m_have ? m_data : data_sram_rdata;
      chk("allowin", 137'(ms_allowin), 137'(!m_valid || (ready && ws_allowin)));
      chk("to_ws_valid", 137'(ms_to_ws_valid), 137'(tv));
      chk("pending", 137'(ms_value_pending), 137'(m_valid && m_inst.res_from_mem && !ready));
      chk("int", 137'(ms_int), 137'(m_valid && (m_inst.ex_cause != 17'd0 || m_inst.ertn)));
      chk("csr", 137'(ms_csr), 137'(m_valid && (m_inst.csr_we || m_inst.csr_rd)));
      chk("tid", 137'(ms_tid), 137'(m_valid && m_inst.rdcntid));
      chk("ds_dest", 137'(ms_to_ds_dest), 137'((m_valid && m_inst.gr_we) ? m_inst.dest : 5'd0));
      if (m_valid) chk("ds_value", 137'(ms_to_ds_value), 137'(model_final(m_inst, rd)));
      if (tv) chk("ws_bus", ms_to_ws_bus, model_bus(m_inst, rd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input inst_t t, input logic req);
    cur_inst         = t;
    es_to_ms_bus     = t;
    es_to_ms_valid   = 1'b1;
    es_to_ms_mem_req = req;
    tick();
    es_to_ms_valid   = 1'b0;
    es_to_ms_mem_req = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t tbl[8] = '{
    '{OP_B,  2'd0, 32'hFFFF_FFE1},
    '{OP_BU, 2'd1, 32'h0000_00F0},
    '{OP_H,  2'd0, 32'hFFFF_F0E1},
    '{OP_HU, 2'd2, 32'h0000_8C7B},
    '{OP_H,  2'd2, 32'hFFFF_8C7B},
    '{OP_B,  2'd2, 32'h0000_007B},
    '{OP_W,  2'd0, 32'h8C7B_F0E1},
    '{OP_BU, 2'd3, 32'h0000_008C}
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    inst_t t;
    tick();
    tick();
    resetn = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    chk("rst_allowin", 137'(ms_allowin), 137'(1'b1));
    chk("rst_valid", 137'(ms_to_ws_valid), 137'(1'b0));
    chk("rst_int", 137'(ms_int), 137'(1'b0));
    tick();

    // ld.b at offset 3, one wait cycle then data_ok
    send(mk_load(OP_B, 32'h1000_0003, 5'd5), 1'b1);
    @(negedge clk);
    chk("ldb_pending", 137'(ms_value_pending), 137'(1'b1));
    chk("ldb_allowin_wait", 137'(ms_allowin), 137'(1'b0));
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_1234;
    @(negedge clk);
    chk("ldb_valid", 137'(ms_to_ws_valid), 137'(1'b1));
    chk("ldb_result", 137'(ms_to_ds_value), 137'(32'hFFFF_FF80));
    chk("ldb_bus_result", 137'(ms_to_ws_bus[63:32]), 137'(32'hFFFF_FF80));
    tick();
    data_sram_data_ok = 1'b0;

    // ld.hu at offset 2, writeback stalled so the data is buffered
    send(mk_load(OP_HU, 32'h1000_0002, 5'd6), 1'b1);
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_0000;
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ldhu_hold_allowin", 137'(ms_allowin), 137'(1'b0));
      chk("ldhu_hold_value", 137'(ms_to_ds_value), 137'(32'h0000_8001));
      tick();
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("ldhu_release_valid", 137'(ms_to_ws_valid), 137'(1'b1));
    chk("ldhu_release_value", 137'(ms_to_ds_value), 137'(32'h0000_8001));
    tick();

    // plain ALU result, no memory request
    t = '0;
    t.gr_we = 1'b1;
    t.dest = 5'd7;
    t.result = 32'h55;
    t.pc = 32'h1c00_0200;
    send(t, 1'b0);
    @(negedge clk);
    chk("add_valid", 137'(ms_to_ws_valid), 137'(1'b1));
    chk("add_dest", 137'(ms_to_ds_dest), 137'(5'd7));
    chk("add_value", 137'(ms_to_ds_value), 137'(32'h55));
    tick();

    // flush while waiting, then a stale response followed by the real one
    send(mk_load(OP_W, 32'h0000_2000, 5'd3), 1'b1);
    ws_reflush_ms = 1'b1;
    tick();
    ws_reflush_ms = 1'b0;
    @(negedge clk);
    chk("flush_allowin", 137'(ms_allowin), 137'(1'b1));
    send(mk_load(OP_W, 32'h0000_2004, 5'd4), 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    @(negedge clk);
    chk("stale_ignored", 137'(ms_to_ws_valid), 137'(1'b0));
    tick();
    data_sram_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    chk("real_valid", 137'(ms_to_ws_valid), 137'(1'b1));
    chk("real_value", 137'(ms_to_ds_value), 137'(32'hAAAA_AAAA));
    tick();
    data_sram_data_ok = 1'b0;

    // address-misaligned load: no request, vaddr passes through
    t = mk_load(OP_W, 32'h0000_1003, 5'd8);
    t.ex_cause[3] = 1'b1;
    t.gr_we = 1'b0;
    t.csr_wmask = 32'h00FF_00FF;
    t.csr_num = 14'h0A5;
    send(t, 1'b0);
    @(negedge clk);
    chk("ale_int", 137'(ms_int), 137'(1'b1));
    chk("ale_value", 137'(ms_to_ds_value), 137'(32'h0000_1003));
    tick();
    t = '0;
    t.ertn = 1'b1;
    send(t, 1'b0);
    @(negedge clk);
    chk("ertn_int", 137'(ms_int), 137'(1'b1));
    tick();
    t = '0;
    t.csr_rd = 1'b1;
    t.rdcntid = 1'b1;
    t.gr_we = 1'b1;
    t.dest = 5'd9;
    send(t, 1'b0);
    @(negedge clk);
    chk("csr_flag", 137'(ms_csr), 137'(1'b1));
    chk("tid_flag", 137'(ms_tid), 137'(1'b1));
    tick();

    // flush coinciding with data_ok: response dropped, no discard armed
    send(mk_load(OP_W, 32'h0000_3000, 5'd10), 1'b1);
    ws_reflush_ms     = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_5555;
    tick();
    ws_reflush_ms     = 1'b0;
    data_sram_data_ok = 1'b0;
    send(mk_load(OP_W, 32'h0000_3004, 5'd11), 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    @(negedge clk);
    chk("coinc_next_valid", 137'(ms_to_ws_valid), 137'(1'b1));
    chk("coinc_next_value", 137'(ms_to_ds_value), 137'(32'h1234_5678));
    tick();
    data_sram_data_ok = 1'b0;

    // alignment/extension table, same-cycle data_ok
    foreach (tbl[k]) begin
      send(mk_load(tbl[k].op, 32'h4000_0000 | 32'(tbl[k].off), 5'd12), 1'b1);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h8C7B_F0E1;
      @(negedge clk);
      chk("align_table", 137'(ms_to_ds_value), 137'(tbl[k].exp));
      tick();
      data_sram_data_ok = 1'b0;
    end

    // reset in the middle of a wait with discard armed
    send(mk_load(OP_W, 32'h0000_5000, 5'd13), 1'b1);
    ws_reflush_ms = 1'b1;
    tick();
    ws_reflush_ms = 1'b0;
    send(mk_load(OP_W, 32'h0000_5004, 5'd14), 1'b1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_mid_allowin", 137'(ms_allowin), 137'(1'b1));
    chk("rst_mid_valid", 137'(ms_to_ws_valid), 137'(1'b0));
    chk("rst_mid_pending", 137'(ms_value_pending), 137'(1'b0));
    send(mk_load(OP_W, 32'h0000_5008, 5'd15), 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0F0F_0F0F;
    @(negedge clk);
    chk("rst_discard_clear", 137'(ms_to_ws_valid), 137'(1'b1));
    chk("rst_discard_value", 137'(ms_to_ds_value), 137'(32'h0F0F_0F0F));
    tick();
    data_sram_data_ok = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
